bwa_seq_mult: RTL and testbench

- Sequential signed multiplier. It consumes one Baugh-Wooley partial-product row per clock and accumulates the rows into a 2*WIDTH-bit two's-complement product.
- It is the accumulating end of the Baugh-Wooley row format used in the hw8 multiplier datapath. Each row is a masked copy of `a` with its MSB inverted.
- It sits between operand registers and result consumers, and uses a start/done handshake.

---
 rtl/bwa_seq_mult.sv | 159 +++++++++++++++
 tb/tb_bwa_seq_mult.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/bwa_seq_mult.sv
// bwa_seq_mult: sequential signed multiplier built on Baugh-Wooley rows.
// One partial-product row is accumulated per clock, so a WIDTH x WIDTH
// product completes WIDTH cycles after the start is accepted.
//
// Optional feature macro: BWA_SIGNED_SEL_EN
//   When defined, the is_signed port selects a signed (1) or unsigned (0)
//   multiply. It is latched together with the operands. When the macro is
//   undefined, the block is signed-only and the port is absent.
//
// Ports:
//   clk       rising-edge clock
//   rst       asynchronous, active-high reset
//   start     multiply request, sampled only while idle
//   a, b      operands, latched on an accepted start
//   is_signed signed/unsigned select (only with BWA_SIGNED_SEL_EN)
//   busy      registered, high while rows are being accumulated
//   done      one-cycle pulse when product updates
//   product   2*WIDTH-bit result, held until the next completion
module bwa_seq_mult #(
    parameter int WIDTH = 32,
    parameter int CW    = $clog2(WIDTH)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic signed [WIDTH-1:0]   a,
    input  logic signed [WIDTH-1:0]   b,
`ifdef BWA_SIGNED_SEL_EN
    input  logic                      is_signed,
`endif
    output logic                      busy,
    output logic                      done,
    output logic signed [2*WIDTH-1:0] product
);

    localparam int PW = 2 * WIDTH;
    // Baugh-Wooley correction constant: 2^WIDTH + 2^(2*WIDTH-1).
    localparam logic [PW-1:0] ACC_INIT = (PW'(1) << WIDTH) | (PW'(1) << (PW - 1));
    localparam logic [CW-1:0] LAST_ROW = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [PW-1:0]    acc_q, acc_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [PW-1:0]    product_q, product_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             sgn_q;
    logic             sgn_d;

`ifdef BWA_SIGNED_SEL_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sgn_q <= 1'b0;
        end else begin
            sgn_q <= sgn_d;
        end
    end
`else
    assign sgn_q = 1'b1;
`endif

    // Row generation: masked copy of a_q, with the Baugh-Wooley inversions
    // (MSB on ordinary rows, all but the MSB on the last row).
    logic [WIDTH-1:0] pp;
    logic [WIDTH-1:0] inv_mask;
    logic [WIDTH-1:0] row;
    logic [PW-1:0]    row_sh;
    logic [PW-1:0]    sum;

    always_comb begin
        pp       = a_q & {WIDTH{b_q[cnt_q]}};
        inv_mask = '0;
        if (sgn_q) begin
            if (cnt_q == LAST_ROW) begin
                inv_mask = {1'b0, {(WIDTH - 1){1'b1}}};
            end else begin
                inv_mask = {1'b1, {(WIDTH - 1){1'b0}}};
            end
        end
        row    = pp ^ inv_mask;
        row_sh = {{WIDTH{1'b0}}, row} << cnt_q;
        sum    = acc_q + row_sh;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        a_d       = a_q;
        b_d       = b_q;
        product_d = product_q;
        done_d    = 1'b0;
        // busy drops on the edge that raises done.
        busy_d    = (state_q == RUN) && (cnt_q != LAST_ROW);
`ifdef BWA_SIGNED_SEL_EN
        sgn_d     = sgn_q;
`else
        sgn_d     = 1'b1;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
`ifdef BWA_SIGNED_SEL_EN
                    sgn_d   = is_signed;
`endif
                    acc_d   = sgn_d ? ACC_INIT : '0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                acc_d = sum;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_ROW) begin
                    product_d = sum;
                    done_d    = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            product_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            a_q       <= a_d;
            b_q       <= b_d;
            product_q <= product_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign product = product_q;

endmodule

// File: tb/tb_bwa_seq_mult.sv
module tb_bwa_seq_mult;

    localparam int WIDTH = 32;

    logic                      clk;
    logic                      rst;
    logic                      start;
    logic signed [WIDTH-1:0]   a;
    logic signed [WIDTH-1:0]   b;
`ifdef BWA_SIGNED_SEL_EN
    logic                      is_signed;
`endif
    logic                      busy;
    logic                      done;
    logic signed [2*WIDTH-1:0] product;

    int errors = 0;
    int checks = 0;

    bwa_seq_mult #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .a        (a),
        .b        (b),
`ifdef BWA_SIGNED_SEL_EN
        .is_signed(is_signed),
`endif
        .busy     (busy),
        .done     (done),
        .product  (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain integer multiplication of the operands.
    function automatic logic [63:0] model(input logic [31:0] x, input logic [31:0] y,
                                          input logic sgn);
        longint sx, sy;
        if (sgn) begin
            sx = longint'($signed(x));
            sy = longint'($signed(y));
            return 64'(sx * sy);
        end
        return {32'b0, x} * {32'b0, y};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_sgn(input logic sgn);
`ifdef BWA_SIGNED_SEL_EN
        is_signed = sgn;
`else
        if (sgn !== 1'b1) $display("note: unsigned request ignored in signed-only build");
`endif
    endtask

    // Called just after a rising edge with the DUT idle.
    task automatic mult(input logic [31:0] ta, input logic [31:0] tbv, input logic sgn,
                        input string tag);
        logic [63:0] exp;
        int lat, bcnt;
        bit seen;
        exp = model(ta, tbv, sgn);
        start = 1'b1;
        a = ta;
        b = tbv;
        set_sgn(sgn);
        @(posedge clk); #1;
        start = 1'b0;
        a = $urandom;
        b = $urandom;
        set_sgn(~sgn);
        lat = 0;
        bcnt = 0;
        seen = 0;
        while (!seen && lat < 3 * WIDTH) begin
            @(posedge clk); #1;
            lat++;
            if (busy) bcnt++;
            if (done) seen = 1;
        end
        chk({tag, "_latency"}, 64'(lat), 64'(WIDTH));
        chk({tag, "_busy_cycles"}, 64'(bcnt), 64'(WIDTH - 1));
        chk({tag, "_product"}, product, exp);
        @(posedge clk); #1;
        chk({tag, "_done_pulse"}, 64'(done), 64'd0);
        chk({tag, "_hold"}, product, exp);
    endtask

    initial begin
        int lat, ndone;
        bit seen;
        logic [31:0] ra, rb;
        logic rs;

        rst = 1'b1;
        start = 1'b0;
        a = '0;
        b = '0;
        set_sgn(1'b1);
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_product", product, 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed operands, including the extremes.
        mult(32'hFFFFFFFD, 32'd5, 1'b1, "neg3x5");
        mult(32'h80000000, 32'h80000000, 1'b1, "minxmin");
        mult(32'h7FFFFFFF, 32'h80000000, 1'b1, "maxxmin");
        mult(32'h00000000, 32'h12345678, 1'b1, "zero");
        mult(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, "m1xm1");

        // start held high through RUN must be ignored; a start in the done
        // cycle is accepted immediately.
        start = 1'b1;
        a = 32'd7;
        b = 32'd6;
        @(posedge clk); #1;
        a = 32'd9;
        b = 32'd9;
        lat = 0;
        seen = 0;
        while (!seen && lat < 3 * WIDTH) begin
            @(posedge clk); #1;
            lat++;
            if (done) seen = 1;
        end
        chk("held_start_latency", 64'(lat), 64'(WIDTH));
        chk("held_start_product", product, 64'd42);
        a = 32'd2;
        b = 32'd3;
        @(posedge clk); #1;
        start = 1'b0;
        a = $urandom;
        b = $urandom;
        chk("b2b_no_extra_done", 64'(done), 64'd0);
        lat = 1;
        seen = 0;
        while (!seen && lat < 3 * WIDTH) begin
            @(posedge clk); #1;
            lat++;
            if (done) seen = 1;
        end
        chk("b2b_latency", 64'(lat), 64'(WIDTH + 1));
        chk("b2b_product", product, 64'd6);
        @(posedge clk); #1;

        // Reset in the middle of a multiply.
        start = 1'b1;
        a = 32'd123;
        b = 32'd456;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        chk("pre_rst_busy", 64'(busy), 64'd1);
        rst = 1'b1;
        #1;
        chk("async_rst_busy", 64'(busy), 64'd0);
        chk("async_rst_done", 64'(done), 64'd0);
        chk("async_rst_product", product, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        ndone = 0;
        for (int i = 0; i < 2 * WIDTH; i++) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        chk("post_rst_no_done", 64'(ndone), 64'd0);
        chk("post_rst_product", product, 64'd0);
        mult($urandom, $urandom, 1'b1, "after_rst");

`ifdef BWA_SIGNED_SEL_EN
        mult(32'hFFFFFFFF, 32'd2, 1'b0, "unsigned_sel");
        mult(32'hFFFFFFFF, 32'd2, 1'b1, "signed_sel");
`endif

        // Random operands against the reference.
        for (int i = 0; i < 8; i++) begin
            ra = $urandom;
            rb = $urandom;
            rs = 1'b1;
`ifdef BWA_SIGNED_SEL_EN
            rs = 1'($urandom_range(0, 1));
`endif
            mult(ra, rb, rs, $sformatf("rand%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
